add8_3_reg: RTL and testbench
=============================

// Module: add8_3_reg
// PURPOSE
//  Registered 8-bit, 3-operand LUT-programmable adder/ALU slice for the datapath.
//  Each bit is a 6-input dual-output LUT (I5 tied 1) whose INIT defines propagate P and generate G.
//  Two chained 4-bit carry cells (MUXCY/XORCY style) form the 8-bit carry chain.
//  Sum and carry-out are captured in output registers, so latency is one clock.
// PARAMETERS
//  INIT  64'h0  LUT truth table, shared by all 8 bits: P uses INIT[63:32], G uses INIT[31:0]
// PORTS
//  clk  in   1  single clock, rising edge; the only clock
//  RST  in   1  synchronous, active-high reset
//  CI   in   1  carry into bit 0
//  I0   in   8  operand 0, bitwise into LUT input 0
//  I1   in   8  operand 1, bitwise into LUT input 1
//  I2   in   8  operand 2, bitwise into LUT input 2
//  op   in   2  operation select, common to all bits (op[0] is LUT input 3, op[1] is LUT input 4)
//  O    out  8  registered sum
//  CO   out  1  registered carry out of bit 7
// BEHAVIOUR
//  - Per-bit index: k = {op[1], op[0], I2[i], I1[i], I0[i]}, range 0..31.
//  - Per-bit LUT outputs: P[i] = INIT[32+k] and G[i] = INIT[k].
//  - Carry chain: c[0] = CI; c[i+1] = P[i] ? c[i] : G[i]; s[i] = P[i] ^ c[i], for i = 0..7.
//  - Carry passes from the low nibble (c[4]) into the high nibble.
//  - CYINIT is 0: CI is the only carry source.
//  - G affects the result only where P = 0.
//  - Combinational core, no internal state except the output registers.
//  - Register update on posedge clk:
//      RST = 1: O <= 8'h00, CO <= 0
//      else:    O <= s[7:0], CO <= c[8]
//  - RST has priority over data capture.
//  - Reset value of every output is 0. Before the first clock edge, outputs are X until RST is applied.
//  - Latency: inputs sampled at edge n appear on O/CO after edge n.
//  - No enable and no handshake: a new result is captured every cycle.
//  - Arithmetic is modulo 256 and wraps; the overflow bit goes to CO only.
//  - op changing every cycle is legal: each cycle uses that cycle's op.
//  - Reset mid-stream discards the in-flight result; the next non-reset edge captures fresh inputs.
// STRUCTURE
//  - Shared package: localparams for the standard INIT tables:
//      INIT_ADD2 = 64'h66666666_88888888 (P = I0^I1, G = I0&I1, op ignored)
//      INIT_ZERO = 64'h0
//      INIT_ONES = {64{1'b1}}
//  - Package also holds the P/G index helper function.
//  - One natural sub-module: carry4_cell (CI, P[3:0], G[3:0] -> S[3:0], CO[3:0]), instantiated twice.
//  - LUT logic is a generate loop of 8 instances in the top level.
//  - Output register lives in the top level.
// TESTING
//  1. INIT_ADD2, RST = 1 for 2 cycles with any inputs -> O = 00, CO = 0.
//  2. INIT_ADD2, I0 = 0F, I1 = 01, CI = 0 -> after 1 edge O = 10, CO = 0.
//     Then I0 = FF, I1 = 01 -> O = 00, CO = 1 (wrap).
//  3. INIT_ADD2, I0 = I1 = 00, CI = 1 -> O = 01, CO = 0.
//     Then I0 = 80, I1 = 80, CI = 1 -> O = 01, CO = 1.
//  4. INIT_ZERO, CI = 1 -> O = 01, CO = 0. CI = 0 -> O = 00, CO = 0 (I0, I1, I2, op ignored).
//  5. INIT_ONES: CI = 0 -> O = FF, CO = 0. CI = 1 -> O = 00, CO = 1 (full chain propagation, nibble crossing).
//  6. RST asserted in the same cycle as valid add inputs -> O = 00, CO = 0 (reset wins).
//     Next edge with RST = 0 -> correct sum.
//     Then random I0/I1/I2/op/CI against a reference model, for each of the three INITs.

Source files
------------

// File: rtl/add8_3_reg_pkg.sv
// Shared definitions for the add8_3_reg LUT-programmable adder slice:
// standard LUT truth tables and the per-bit LUT index helper.
package add8_3_reg_pkg;

    // Two-operand add: P = I0 ^ I1, G = I0 & I1, op and I2 ignored.
    localparam logic [63:0] INIT_ADD2 = 64'h66666666_88888888;
    // P = 0, G = 0 everywhere: only CI reaches bit 0 of the sum.
    localparam logic [63:0] INIT_ZERO = 64'h0;
    // P = 1, G = 1 everywhere: every bit propagates the incoming carry.
    localparam logic [63:0] INIT_ONES = {64{1'b1}};

    // LUT address for one bit: {op[1], op[0], I2, I1, I0}; I5 is tied high,
    // which selects INIT[63:32] for P and INIT[31:0] for G.
    function automatic logic [4:0] lut_index(
        input logic [1:0] op,
        input logic       i2,
        input logic       i1,
        input logic       i0
    );
        return {op, i2, i1, i0};
    endfunction

endpackage

// File: rtl/add8_3_reg_carry4_cell.sv
// Four-bit MUXCY/XORCY style carry cell: each bit either passes the
// incoming carry (P = 1) or replaces it with G (P = 0).
module carry4_cell (
    input  logic       ci,
    input  logic [3:0] p,
    input  logic [3:0] g,
    output logic [3:0] s,
    output logic [3:0] co
);

    // Ripple the carry through the four mux/xor stages.
    always_comb begin
        logic c;
        // NOTE: blocking assignments here model the ripple in order and every
        // output gets a default first, so no latch is inferred.
        s  = '0;
        co = '0;
        c  = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]  = p[i] ^ c;
            c     = p[i] ? c : g[i];
            co[i] = c;
        end
    end

endmodule

// File: rtl/add8_3_reg.sv
// Registered 8-bit, 3-operand LUT-programmable adder/ALU slice.
// Eight LUTs produce per-bit propagate/generate from INIT, two carry4_cell
// instances form the carry chain, and sum plus carry-out are registered.
module add8_3_reg
    import add8_3_reg_pkg::*;
#(
    parameter logic [63:0] INIT = 64'h0
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       CI,
    input  logic [7:0] I0,
    input  logic [7:0] I1,
    input  logic [7:0] I2,
    input  logic [1:0] op,
    output logic [7:0] O,
    output logic       CO
);

    localparam logic [31:0] P_TABLE = INIT[63:32];
    localparam logic [31:0] G_TABLE = INIT[31:0];

    logic [7:0] p;
    logic [7:0] g;
    logic [7:0] s;
    logic [3:0] co_lo;
    logic [3:0] co_hi;

    // One LUT per bit; all bits share the same truth table and op.
    for (genvar i = 0; i < 8; i++) begin : g_lut
        logic [4:0] k;
        assign k    = lut_index(op, I2[i], I1[i], I0[i]);
        assign p[i] = P_TABLE[k];
        assign g[i] = G_TABLE[k];
    end

    carry4_cell u_carry_lo (
        .ci (CI),
        .p  (p[3:0]),
        .g  (g[3:0]),
        .s  (s[3:0]),
        .co (co_lo)
    );

    // The low nibble's final carry (c[4]) feeds the high nibble.
    carry4_cell u_carry_hi (
        .ci (co_lo[3]),
        .p  (p[7:4]),
        .g  (g[7:4]),
        .s  (s[7:4]),
        .co (co_hi)
    );

    // Intermediate carries exist only for the chain; nothing outside uses them.
    logic unused_carries;
    assign unused_carries = ^{co_lo[2:0], co_hi[2:0]};

    // Output register: reset wins over capture, new result every cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for state so all registers update
        // together from pre-edge values.
        if (RST) begin
            O  <= 8'h00;
            CO <= 1'b0;
        end else begin
            O  <= s;
            CO <= co_hi[3];
        end
    end

endmodule

// File: tb/tb_add8_3_reg.sv
// Directed and random checks of add8_3_reg using three instances, one per
// standard INIT table, all driven by the same inputs.
module tb_add8_3_reg;
    import add8_3_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ci;
    logic [7:0] i0, i1, i2;
    logic [1:0] op;

    logic [7:0] o_add, o_zero, o_ones;
    logic       co_add, co_zero, co_ones;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    add8_3_reg #(.INIT(INIT_ADD2)) dut_add (
        .clk(clk), .RST(rst), .CI(ci), .I0(i0), .I1(i1), .I2(i2), .op(op),
        .O(o_add), .CO(co_add)
    );

    add8_3_reg #(.INIT(INIT_ZERO)) dut_zero (
        .clk(clk), .RST(rst), .CI(ci), .I0(i0), .I1(i1), .I2(i2), .op(op),
        .O(o_zero), .CO(co_zero)
    );

    add8_3_reg #(.INIT(INIT_ONES)) dut_ones (
        .clk(clk), .RST(rst), .CI(ci), .I0(i0), .I1(i1), .I2(i2), .op(op),
        .O(o_ones), .CO(co_ones)
    );

    // Compare {CO, O} against the expected value and count the result.
    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got CO=%b O=%h, expected CO=%b O=%h",
                     tag, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    // Drive one set of inputs, let one rising edge capture them, sample after.
    task automatic apply(input logic r, input logic c, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] d, input logic [1:0] o);
        rst = r; ci = c; i0 = a; i1 = b; i2 = d; op = o;
        @(posedge clk);
        #1;
    endtask

    // Reference results for each INIT, written from the table meanings.
    function automatic logic [8:0] ref_add(input logic c, input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} + {1'b0, b} + {8'b0, c};
    endfunction

    function automatic logic [8:0] ref_zero(input logic c);
        return {8'b0, c};
    endfunction

    function automatic logic [8:0] ref_ones(input logic c);
        return c ? 9'h100 : 9'h0FF;
    endfunction

    // Apply inputs (no reset) and check all three instances against the models.
    task automatic run_all(input string tag, input logic c, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] d, input logic [1:0] o);
        apply(1'b0, c, a, b, d, o);
        check({tag, "/add"},  {co_add,  o_add},  ref_add(c, a, b));
        check({tag, "/zero"}, {co_zero, o_zero}, ref_zero(c));
        check({tag, "/ones"}, {co_ones, o_ones}, ref_ones(c));
    endtask

    initial begin
        rst = 1'b1; ci = 1'b1; i0 = 8'hA5; i1 = 8'h3C; i2 = 8'hFF; op = 2'b11;

        // Reset held for two cycles with non-zero inputs.
        apply(1'b1, 1'b1, 8'hA5, 8'h3C, 8'hFF, 2'b11);
        apply(1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 2'b10);
        check("rst/add",  {co_add,  o_add},  9'h000);
        check("rst/zero", {co_zero, o_zero}, 9'h000);
        check("rst/ones", {co_ones, o_ones}, 9'h000);

        // Directed add vectors with hand-computed results.
        apply(1'b0, 1'b0, 8'h0F, 8'h01, 8'h00, 2'b00);
        check("add 0F+01", {co_add, o_add}, 9'h010);
        apply(1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 2'b00);
        check("add FF+01 wrap", {co_add, o_add}, 9'h100);
        apply(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'b00);
        check("add 00+00+ci", {co_add, o_add}, 9'h001);
        apply(1'b0, 1'b1, 8'h80, 8'h80, 8'h00, 2'b00);
        check("add 80+80+ci", {co_add, o_add}, 9'h101);
        // op and I2 must not matter for the two-operand table.
        apply(1'b0, 1'b0, 8'h0F, 8'h01, 8'hAA, 2'b11);
        check("add op ignored", {co_add, o_add}, 9'h010);

        // Zero table: only CI reaches the sum.
        apply(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 2'b11);
        check("zero ci=1", {co_zero, o_zero}, 9'h001);
        apply(1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 2'b01);
        check("zero ci=0", {co_zero, o_zero}, 9'h000);

        // Ones table: full-chain propagation across the nibble boundary.
        apply(1'b0, 1'b0, 8'h12, 8'h34, 8'h56, 2'b10);
        check("ones ci=0", {co_ones, o_ones}, 9'h0FF);
        apply(1'b0, 1'b1, 8'h12, 8'h34, 8'h56, 2'b10);
        check("ones ci=1", {co_ones, o_ones}, 9'h100);

        // Reset in the same cycle as valid add inputs wins; next edge recovers.
        apply(1'b1, 1'b0, 8'h0F, 8'h01, 8'h00, 2'b00);
        check("rst wins/add",  {co_add,  o_add},  9'h000);
        check("rst wins/ones", {co_ones, o_ones}, 9'h000);
        apply(1'b0, 1'b0, 8'h0F, 8'h01, 8'h00, 2'b00);
        check("post rst add", {co_add, o_add}, 9'h010);

        // Random stimulus against the reference models for all three tables.
        for (int n = 0; n < 40; n++) begin
            run_all("rand", 1'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 2'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
